ahb5_slave_sram: RTL and testbench

AHB5_SLAVE_SRAM -- requirements
Module: ahb5_slave_sram

---
 rtl/ahb5_pkg.sv | 32 +++
 rtl/ahb5_excl_monitor.sv | 44 ++++
 rtl/ahb5_slave_sram.sv | 203 ++++++++++++++++++++
 tb/tb_ahb5_slave_sram.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb5_pkg.sv
// Shared AHB5 types and constants for the SRAM slave and its exclusive monitor.
package ahb5_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_t;

    typedef enum logic [2:0] {
        HSIZE_BYTE   = 3'd0,
        HSIZE_HALF   = 3'd1,
        HSIZE_WORD   = 3'd2,
        HSIZE_DWORD  = 3'd3,
        HSIZE_4WORD  = 3'd4,
        HSIZE_8WORD  = 3'd5,
        HSIZE_16WORD = 3'd6,
        HSIZE_32WORD = 3'd7
    } hsize_t;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ERR1 = 2'd2,
        ST_ERR2 = 2'd3
    } state_t;

endpackage

// File: rtl/ahb5_excl_monitor.sv
// Single-entry exclusive access monitor: remembers the master and word of the
// last exclusive read and reports whether an exclusive write may succeed.
module ahb5_excl_monitor #(
    parameter int MST_W = 4,
    parameter int IDX_W = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             update,
    input  logic             excl,
    input  logic             write,
    input  logic [MST_W-1:0] master,
    input  logic [IDX_W-1:0] word_idx,
    output logic             match
);

    logic             valid;
    logic [MST_W-1:0] mon_master;
    logic [IDX_W-1:0] mon_idx;

    assign match = valid && (mon_master == master) && (mon_idx == word_idx);

    // Updates happen when a legal transfer is accepted, so later transfers see the effect in order
    always_ff @(posedge clk) begin
        if (reset) begin
            valid      <= 1'b0;
            mon_master <= '0;
            mon_idx    <= '0;
        end else if (update) begin
            if (excl && !write) begin
                valid      <= 1'b1;
                mon_master <= master;
                mon_idx    <= word_idx;
            end else if (excl && write) begin
                if (match) begin
                    valid <= 1'b0;
                end
            end else if (write && valid && (mon_idx == word_idx)) begin
                valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/ahb5_slave_sram.sv
// AHB5 SRAM slave with optional wait states, two-cycle ERROR for illegal
// transfers, byte-lane writes, write-to-read forwarding and exclusive access.
module ahb5_slave_sram
    import ahb5_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int DEPTH       = 1024,
    parameter int WAIT_STATES = 0,
    parameter int MST_W       = 4
) (
    input  logic              HCLK,
    input  logic              HRESET,
    input  logic              HSEL,
    input  logic [ADDR_W-1:0] HADDR,
    input  logic [1:0]        HTRANS,
    input  logic              HWRITE,
    input  logic [2:0]        HSIZE,
    input  logic              HREADY,
    input  logic              HEXCL,
    input  logic [MST_W-1:0]  HMASTER,
    input  logic [DATA_W-1:0] HWDATA,
    output logic [DATA_W-1:0] HRDATA,
    output logic              HREADYOUT,
    output logic              HRESP,
    output logic              HEXOKAY
);

    localparam int NBYTES    = DATA_W / 8;
    localparam int BYTE_BITS = $clog2(NBYTES);
    localparam int IDX_W     = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];

    state_t            state;
    logic [2:0]        cnt;
    logic              hreadyout_r;
    logic              hresp_r;
    logic              hexokay_r;
    logic [DATA_W-1:0] hrdata_r;

    logic              dp_valid;
    logic              dp_write;
    logic              dp_wen;
    logic              dp_hx;
    logic [IDX_W-1:0]  dp_idx;
    logic [NBYTES-1:0] dp_be;

    htrans_t           trans;
    logic              take;
    logic              legal;
    logic              size_ok;
    logic              align_ok;
    logic              range_ok;
    logic [ADDR_W-1:0] align_mask;
    logic [IDX_W-1:0]  addr_idx;
    logic [BYTE_BITS-1:0] lane_lo;
    logic [NBYTES-1:0] be;
    logic              mon_match;
    logic              hx_next;
    logic              wen_next;
    logic              commit;
    logic [DATA_W-1:0] wr_word;
    logic [DATA_W-1:0] fwd_rdata;

    assign trans    = htrans_t'(HTRANS);
    assign addr_idx = HADDR[BYTE_BITS +: IDX_W];
    assign lane_lo  = HADDR[BYTE_BITS-1:0];

    // An address phase is only taken when the slave itself is ready for one
    assign take = HSEL && HREADY && ((trans == HTRANS_NONSEQ) || (trans == HTRANS_SEQ))
                  && ((state == ST_IDLE) || (state == ST_ERR2));

    // Legality: size fits the bus, address aligned to size, word inside the array
    always_comb begin
        size_ok    = (HSIZE <= 3'(BYTE_BITS));
        align_mask = (ADDR_W'(1) << HSIZE) - ADDR_W'(1);
        align_ok   = ((HADDR & align_mask) == '0);
        range_ok   = ((HADDR >> BYTE_BITS) < ADDR_W'(DEPTH));
        legal      = size_ok && align_ok && range_ok;
    end

    // Byte lanes touched by the transfer, from size and low address bits
    always_comb begin
        be = '0;
        for (int i = 0; i < NBYTES; i++) begin
            if ((i >= int'(lane_lo)) && (i < int'(lane_lo) + (1 << int'(HSIZE)))) begin
                be[i] = 1'b1;
            end
        end
    end

    assign hx_next  = HEXCL && (!HWRITE || mon_match);
    assign wen_next = HWRITE && (!HEXCL || mon_match);

    // The pending write lands at the end of the last data-phase cycle
    assign commit = (state == ST_IDLE) && dp_valid && dp_wen;

    // Merge write data into the stored word and forward it to an overlapping read
    always_comb begin
        wr_word = mem[dp_idx];
        for (int i = 0; i < NBYTES; i++) begin
            if (dp_be[i]) begin
                wr_word[8*i +: 8] = HWDATA[8*i +: 8];
            end
        end
        fwd_rdata = (commit && (dp_idx == addr_idx)) ? wr_word : mem[addr_idx];
    end

    ahb5_excl_monitor #(
        .MST_W (MST_W),
        .IDX_W (IDX_W)
    ) u_excl_monitor (
        .clk      (HCLK),
        .reset    (HRESET),
        .update   (take && legal),
        .excl     (HEXCL),
        .write    (HWRITE),
        .master   (HMASTER),
        .word_idx (addr_idx),
        .match    (mon_match)
    );

    // Memory array is never reset; writes are blocked while reset is held
    always_ff @(posedge HCLK) begin
        if (!HRESET && commit) begin
            mem[dp_idx] <= wr_word;
        end
    end

    // Transfer FSM with registered response outputs
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            hreadyout_r <= 1'b1;
            hresp_r     <= HRESP_OKAY;
            hexokay_r   <= 1'b0;
            hrdata_r    <= '0;
            dp_valid    <= 1'b0;
            dp_write    <= 1'b0;
            dp_wen      <= 1'b0;
            dp_hx       <= 1'b0;
            dp_idx      <= '0;
            dp_be       <= '0;
        end else begin
            case (state)
                ST_WAIT: begin
                    if (cnt == 3'd1) begin
                        state       <= ST_IDLE;
                        cnt         <= '0;
                        hreadyout_r <= 1'b1;
                        hexokay_r   <= dp_hx;
                        hrdata_r    <= dp_write ? '0 : mem[dp_idx];
                    end else begin
                        cnt <= cnt - 3'd1;
                    end
                end
                ST_ERR1: begin
                    state       <= ST_ERR2;
                    hreadyout_r <= 1'b1;
                    hresp_r     <= HRESP_ERROR;
                end
                default: begin
                    state       <= ST_IDLE;
                    hreadyout_r <= 1'b1;
                    hresp_r     <= HRESP_OKAY;
                    hexokay_r   <= 1'b0;
                    hrdata_r    <= '0;
                    dp_valid    <= 1'b0;
                    if (take) begin
                        if (!legal) begin
                            state       <= ST_ERR1;
                            hreadyout_r <= 1'b0;
                            hresp_r     <= HRESP_ERROR;
                        end else begin
                            dp_valid <= 1'b1;
                            dp_write <= HWRITE;
                            dp_wen   <= wen_next;
                            dp_hx    <= hx_next;
                            dp_idx   <= addr_idx;
                            dp_be    <= be;
                            if (WAIT_STATES == 0) begin
                                hexokay_r <= hx_next;
                                hrdata_r  <= HWRITE ? '0 : fwd_rdata;
                            end else begin
                                state       <= ST_WAIT;
                                cnt         <= 3'(WAIT_STATES);
                                hreadyout_r <= 1'b0;
                            end
                        end
                    end
                end
            endcase
        end
    end

    assign HRDATA    = hrdata_r;
    assign HREADYOUT = hreadyout_r;
    assign HRESP     = hresp_r;
    assign HEXOKAY   = hexokay_r;

endmodule

// File: tb/tb_ahb5_slave_sram.sv
// Bench for ahb5_slave_sram: two instances (zero and three wait states) driven
// by a pipelined bus driver and checked against a sequential transfer model.
module tb_ahb5_slave_sram;

    localparam int DEPTH = 1024;

    logic HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    logic        HRESET;
    logic        hsel;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic        hexcl;
    logic [3:0]  hmaster;
    logic [31:0] hwdata;
    int          sel;

    logic [31:0] rdata0, rdata3;
    logic        ro0, ro3, resp0, resp3, hx0, hx3;
    logic        hsel0, hsel3;
    logic        curReady, curResp, curHx;
    logic [31:0] curRdata;

    assign hsel0    = hsel && (sel == 0);
    assign hsel3    = hsel && (sel == 1);
    assign curReady = (sel == 1) ? ro3 : ro0;
    assign curResp  = (sel == 1) ? resp3 : resp0;
    assign curHx    = (sel == 1) ? hx3 : hx0;
    assign curRdata = (sel == 1) ? rdata3 : rdata0;

    ahb5_slave_sram #(.DATA_W(32), .ADDR_W(32), .DEPTH(DEPTH), .WAIT_STATES(0), .MST_W(4)) dut0 (
        .HCLK(HCLK), .HRESET(HRESET), .HSEL(hsel0), .HADDR(haddr), .HTRANS(htrans),
        .HWRITE(hwrite), .HSIZE(hsize), .HREADY(ro0), .HEXCL(hexcl), .HMASTER(hmaster),
        .HWDATA(hwdata), .HRDATA(rdata0), .HREADYOUT(ro0), .HRESP(resp0), .HEXOKAY(hx0));

    ahb5_slave_sram #(.DATA_W(32), .ADDR_W(32), .DEPTH(DEPTH), .WAIT_STATES(3), .MST_W(4)) dut3 (
        .HCLK(HCLK), .HRESET(HRESET), .HSEL(hsel3), .HADDR(haddr), .HTRANS(htrans),
        .HWRITE(hwrite), .HSIZE(hsize), .HREADY(ro3), .HEXCL(hexcl), .HMASTER(hmaster),
        .HWDATA(hwdata), .HRDATA(rdata3), .HREADYOUT(ro3), .HRESP(resp3), .HEXOKAY(hx3));

    // kind: 0 real transfer, 1 IDLE, 2 BUSY, 3 NONSEQ with HSEL low
    typedef struct {
        int          kind;
        bit          write;
        logic [31:0] addr;
        logic [2:0]  size;
        bit          excl;
        logic [3:0]  master;
        logic [31:0] wdata;
    } xfer_t;

    typedef struct {
        bit          err;
        bit          isRead;
        bit          hx;
        logic [31:0] rdata;
        logic [31:0] wdata;
        int          waits;
    } expect_t;

    xfer_t       q[$];
    logic [31:0] modelMem [2][DEPTH];
    bit          monValid [2];
    logic [3:0]  monMaster [2];
    int          monWord [2];
    int          errors = 0;
    int          checks = 0;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s (dut %0d, t=%0t): got %0h expected %0h", tag, sel, $time, actual, expected);
        end
    endtask

    // Sequential transfer semantics: apply one transfer to the model and predict its response
    function automatic void modelTransfer(input xfer_t t, output expect_t e);
        int          d;
        int          w;
        int          off;
        int          nb;
        bit          hit;
        bit          doWrite;
        logic [31:0] word;
        d        = sel;
        w        = int'(t.addr >> 2);
        off      = int'(t.addr % 32'd4);
        nb       = 1 << int'(t.size);
        e.wdata  = t.wdata;
        e.isRead = !t.write;
        e.hx     = 1'b0;
        e.rdata  = 32'h0;
        if ((t.addr >= 32'(DEPTH * 4)) || (t.size > 3'd2) || ((off % nb) != 0)) begin
            e.err   = 1'b1;
            e.waits = 1;
            return;
        end
        e.err   = 1'b0;
        e.waits = (d == 1) ? 3 : 0;
        if (!t.write) begin
            e.rdata = modelMem[d][w];
            if (t.excl) begin
                monValid[d]  = 1'b1;
                monMaster[d] = t.master;
                monWord[d]   = w;
                e.hx         = 1'b1;
            end
        end else begin
            doWrite = 1'b1;
            hit     = monValid[d] && (monWord[d] == w);
            if (t.excl) begin
                if (hit && (monMaster[d] == t.master)) begin
                    e.hx        = 1'b1;
                    monValid[d] = 1'b0;
                end else begin
                    doWrite = 1'b0;
                end
            end else if (hit) begin
                monValid[d] = 1'b0;
            end
            if (doWrite) begin
                word = modelMem[d][w];
                for (int b = off; b < off + nb; b++) begin
                    word[8*b +: 8] = t.wdata[8*b +: 8];
                end
                modelMem[d][w] = word;
            end
        end
    endfunction

    function automatic void addXfer(input bit write, input logic [31:0] addr, input logic [2:0] size,
                                    input bit excl, input logic [3:0] master, input logic [31:0] wdata);
        xfer_t t;
        t.kind   = 0;
        t.write  = write;
        t.addr   = addr;
        t.size   = size;
        t.excl   = excl;
        t.master = master;
        t.wdata  = wdata;
        q.push_back(t);
    endfunction

    function automatic xfer_t randXfer();
        xfer_t t;
        int    r;
        int    off;
        r        = int'($urandom_range(0, 99));
        t.kind   = (r < 4) ? 1 : (r < 7) ? 2 : (r < 10) ? 3 : 0;
        t.write  = 1'($urandom_range(0, 1));
        t.excl   = ($urandom_range(0, 3) == 0);
        t.master = 4'($urandom_range(0, 3));
        t.size   = ($urandom_range(0, 19) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
        off      = int'($urandom_range(0, 3));
        if ($urandom_range(0, 9) != 0) begin
            off = off & ~((1 << int'(t.size)) - 1);
        end
        t.addr   = 32'($urandom_range(0, 15) * 4 + off);
        if ($urandom_range(0, 19) == 0) begin
            t.addr = t.addr | 32'h0000_1000;
        end
        t.wdata  = $urandom;
        return t;
    endfunction

    task automatic driveIdle();
        hsel    = 1'b1;
        htrans  = 2'b00;
        hwrite  = 1'b0;
        hexcl   = 1'b0;
        haddr   = 32'h0;
        hsize   = 3'd2;
        hmaster = 4'd0;
    endtask

    task automatic driveAddr(input xfer_t t);
        haddr   = t.addr;
        hsize   = t.size;
        hexcl   = t.excl;
        hmaster = t.master;
        hwrite  = t.write;
        case (t.kind)
            0: begin hsel = 1'b1; htrans = ($urandom_range(0, 1) == 0) ? 2'b10 : 2'b11; end
            1: begin hsel = 1'b1; htrans = 2'b00; end
            2: begin hsel = 1'b1; htrans = 2'b01; end
            default: begin hsel = 1'b0; htrans = 2'b10; hwrite = 1'b1; end
        endcase
    endtask

    // Pipelined driver: next address phase overlaps the final data-phase cycle of the previous one
    task automatic applyStimulus();
        int          idx   = 0;
        bit          haveDp = 1'b0;
        expect_t     dp;
        int          waits = 0;
        int          guard = 0;
        int          limit = 10 * q.size() + 20;
        logic        rdy;
        logic [31:0] wd;
        dp = '{default: 0};
        while (((idx < q.size()) || haveDp) && (guard < limit)) begin
            @(negedge HCLK);
            guard++;
            rdy = curReady;
            wd  = haveDp ? dp.wdata : $urandom;
            if (haveDp) begin
                if (rdy) begin
                    checkOutput("waitCycles", 64'(waits), 64'(dp.waits));
                    checkOutput("finalResp", 64'(curResp), 64'(dp.err));
                    checkOutput("finalExOkay", 64'(curHx), 64'(dp.hx));
                    if (!dp.err) begin
                        checkOutput("finalRdata", 64'(curRdata), 64'(dp.isRead ? dp.rdata : 32'h0));
                    end
                    haveDp = 1'b0;
                end else begin
                    waits++;
                    checkOutput("waitResp", 64'(curResp), 64'(dp.err));
                    checkOutput("waitExOkay", 64'(curHx), 64'(0));
                    checkOutput("waitRdata", 64'(curRdata), 64'(0));
                end
            end else begin
                checkOutput("idleReady", 64'(rdy), 64'(1));
                checkOutput("idleResp", 64'(curResp), 64'(0));
                checkOutput("idleExOkay", 64'(curHx), 64'(0));
            end
            hwdata = wd;
            if (rdy && (idx < q.size())) begin
                driveAddr(q[idx]);
                if (q[idx].kind == 0) begin
                    modelTransfer(q[idx], dp);
                    haveDp = 1'b1;
                    waits  = 0;
                end
                idx++;
            end else begin
                driveIdle();
            end
        end
        checkOutput("drained", 64'((q.size() - idx) + int'(haveDp)), 64'(0));
        q.delete();
    endtask

    initial begin
        sel     = 0;
        HRESET  = 1'b1;
        hwdata  = 32'h0;
        driveIdle();
        for (int d = 0; d < 2; d++) begin
            monValid[d]  = 1'b0;
            monMaster[d] = 4'd0;
            monWord[d]   = 0;
        end
        repeat (3) @(negedge HCLK);
        checkOutput("rstReady0", 64'(ro0), 64'(1));
        checkOutput("rstResp0", 64'(resp0), 64'(0));
        checkOutput("rstExOkay0", 64'(hx0), 64'(0));
        checkOutput("rstRdata0", 64'(rdata0), 64'(0));
        checkOutput("rstReady3", 64'(ro3), 64'(1));
        checkOutput("rstResp3", 64'(resp3), 64'(0));
        checkOutput("rstRdata3", 64'(rdata3), 64'(0));
        HRESET = 1'b0;

        // Give every word the random phase may read a defined value in both instances
        for (int s = 0; s < 2; s++) begin
            sel = s;
            for (int w = 0; w < 16; w++) addXfer(1'b1, 32'(w * 4), 3'd2, 1'b0, 4'd0, $urandom);
            applyStimulus();
        end

        // Zero-wait: back-to-back write/read with forwarding
        sel = 0;
        addXfer(1'b1, 32'h10, 3'd2, 1'b0, 4'd0, 32'hDEADBEEF);
        addXfer(1'b0, 32'h10, 3'd2, 1'b0, 4'd0, 32'h0);
        applyStimulus();

        // Out-of-range word and misaligned halfword both error without touching memory
        addXfer(1'b1, 32'h1000, 3'd2, 1'b0, 4'd0, 32'h5A5A5A5A);
        addXfer(1'b0, 32'h0, 3'd2, 1'b0, 4'd0, 32'h0);
        addXfer(1'b1, 32'h3, 3'd1, 1'b0, 4'd0, 32'hA5A5A5A5);
        addXfer(1'b0, 32'h0, 3'd2, 1'b0, 4'd0, 32'h0);
        addXfer(1'b0, 32'h1000, 3'd2, 1'b1, 4'd3, 32'h0);
        addXfer(1'b1, 32'h0, 3'd2, 1'b1, 4'd3, 32'h77777777);
        applyStimulus();

        // Exclusive pair succeeds; interleaved plain write from another master breaks it
        addXfer(1'b0, 32'h20, 3'd2, 1'b1, 4'd2, 32'h0);
        addXfer(1'b1, 32'h20, 3'd2, 1'b1, 4'd2, 32'h55);
        addXfer(1'b0, 32'h20, 3'd2, 1'b0, 4'd0, 32'h0);
        addXfer(1'b0, 32'h20, 3'd2, 1'b1, 4'd2, 32'h0);
        addXfer(1'b1, 32'h20, 3'd2, 1'b0, 4'd1, 32'h99);
        addXfer(1'b1, 32'h20, 3'd2, 1'b1, 4'd2, 32'h55);
        addXfer(1'b0, 32'h20, 3'd2, 1'b0, 4'd0, 32'h0);
        applyStimulus();

        // Byte-lane write into the middle of a word
        addXfer(1'b1, 32'h40, 3'd2, 1'b0, 4'd0, 32'h11223344);
        addXfer(1'b1, 32'h41, 3'd0, 1'b0, 4'd0, 32'hABABABAB);
        addXfer(1'b0, 32'h40, 3'd2, 1'b0, 4'd0, 32'h0);
        applyStimulus();

        // Three wait states: read word 0, then byte write and readback
        sel = 1;
        addXfer(1'b0, 32'h0, 3'd2, 1'b0, 4'd0, 32'h0);
        addXfer(1'b1, 32'h40, 3'd2, 1'b0, 4'd0, 32'h11223344);
        addXfer(1'b1, 32'h41, 3'd0, 1'b0, 4'd0, 32'hABABABAB);
        addXfer(1'b0, 32'h40, 3'd2, 1'b0, 4'd0, 32'h0);
        addXfer(1'b1, 32'h1000, 3'd2, 1'b0, 4'd0, 32'h0);
        applyStimulus();

        // Reset during a wait cycle abandons the write
        @(negedge HCLK);
        checkOutput("preRstReady", 64'(curReady), 64'(1));
        hsel = 1'b1; htrans = 2'b10; hwrite = 1'b1; haddr = 32'h0; hsize = 3'd2; hexcl = 1'b0; hmaster = 4'd0;
        @(negedge HCLK);
        checkOutput("rstWaitLow", 64'(curReady), 64'(0));
        driveIdle();
        hwdata = 32'hCAFEF00D;
        HRESET = 1'b1;
        @(negedge HCLK);
        HRESET = 1'b0;
        checkOutput("rstMidReady", 64'(curReady), 64'(1));
        checkOutput("rstMidResp", 64'(curResp), 64'(0));
        checkOutput("rstMidRdata", 64'(curRdata), 64'(0));
        monValid[0] = 1'b0;
        monValid[1] = 1'b0;
        addXfer(1'b0, 32'h0, 3'd2, 1'b0, 4'd0, 32'h0);
        applyStimulus();

        // Randomized mixed traffic on both instances
        for (int s = 0; s < 2; s++) begin
            sel = s;
            for (int n = 0; n < 200; n++) q.push_back(randXfer());
            applyStimulus();
        end

        @(negedge HCLK);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
